// File: rtl/fht_io_pkg.sv
// Shared definitions for the FHT host I/O controller: point count, FSM encoding and bit reversal.
package fht_io_pkg;
   localparam int A_BIT_DEF = 8;
   localparam int LOG2_N    = A_BIT_DEF + 2;
   localparam int N_POINT   = 1 << LOG2_N;
   localparam int MAX_IDX_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      UNLOAD = 3'd4
   } fht_io_state_e;

   // Reverses the low `width` bits of v; bits at and above `width` come back as zero.
   function automatic logic [MAX_IDX_W-1:0] bit_rev(input logic [MAX_IDX_W-1:0] v, input int width);
      logic [MAX_IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_IDX_W; i++) begin
         if (i < width) r[width-1-i] = v[i];
      end
      return r;
   endfunction
endpackage

// File: rtl/fht_io_skid.sv
// Small credit-managed FIFO holding bank read data until the output stream accepts it.
// The issuer never has more than DEPTH reads in flight plus stored, so pushes never overflow.
module fht_io_skid
   import fht_io_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 2,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          iCLK,
   input  logic          iRESET,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push_i && (count_q != CW'(DEPTH));
      do_pop   = pop_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;
endmodule

// File: rtl/fht_io_control.sv
// Host-side sample loader / result unloader for the 4-bank FHT engine.
// Define FHT_IO_BITREV_EN to load in bit-reversed order; otherwise the load is natural order.
module fht_io_control
   import fht_io_pkg::*;
#(
   parameter int A_BIT     = A_BIT_DEF,
   parameter int START_LEN = 4,
   parameter int RD_LAT    = 1
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iIN_VALID,
   output logic             oIN_READY,
   output logic             oIN_LAST_ERR,
   input  logic             iIN_LAST,
   output logic [A_BIT-1:0] oWR_ADDR,
   output logic [3:0]       oWR_EN,
   output logic             oFHT_START,
   input  logic             iFHT_RDY,
   input  logic             iFHT_SOURCE,
   output logic             oRD_SET,
   output logic [A_BIT-1:0] oRD_ADDR,
   output logic [1:0]       oRD_BANK,
   input  logic [15:0]      iRD_DATA,
   output logic [15:0]      oOUT_DATA,
   output logic             oOUT_VALID,
   input  logic             iOUT_READY,
   output logic             oOUT_LAST,
   output logic             oBUSY,
   output logic [2:0]       oDBG_STATE
);
   localparam int LOGN  = A_BIT + 2;
   localparam int NPT   = 1 << LOGN;
   localparam int DEPTH = RD_LAT + 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [LOGN-1:0] LAST_IDX = LOGN'(NPT - 1);

   fht_io_state_e     state_q, state_d;
   logic [LOGN-1:0]   idx_q, idx_d;
   logic [LOGN-1:0]   k_q, k_d;
   logic [LOGN-1:0]   out_cnt_q, out_cnt_d;
   logic              issue_done_q, issue_done_d;
   logic [7:0]        start_cnt_q, start_cnt_d;
   logic              rdy_prev_q;
   logic              seen_low_q, seen_low_d;
   logic              rd_set_q, rd_set_d;
   logic              last_err_q, last_err_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;

   logic [LOGN-1:0]   r;
   logic              in_hs, out_hs, issue, rdy_rise, is_last_idx;
   logic [7:0]        inflight, used;
   logic [CW-1:0]     skid_count;
   logic              skid_valid;
   logic [15:0]       skid_data;

   always_comb begin
`ifdef FHT_IO_BITREV_EN
      r = LOGN'(bit_rev(MAX_IDX_W'(idx_q), LOGN));
`else
      r = idx_q;
`endif
   end

   assign in_hs       = (state_q == LOAD) && iIN_VALID;
   assign is_last_idx = (idx_q == LAST_IDX);
   assign out_hs      = skid_valid && iOUT_READY;
   assign rdy_rise    = iFHT_RDY && !rdy_prev_q && seen_low_q;

   // Reads in flight plus stored data must never exceed the skid depth; a pop this cycle frees a slot.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(pipe_q[i]);
      used   = 8'(skid_count) + inflight - 8'(out_hs);
      issue  = (state_q == UNLOAD) && !issue_done_q && (used < 8'(DEPTH));
      pipe_d = RD_LAT'({pipe_q, issue});
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      k_d          = k_q;
      out_cnt_d    = out_cnt_q;
      issue_done_d = issue_done_q;
      start_cnt_d  = '0;
      seen_low_d   = 1'b0;
      rd_set_d     = rd_set_q;
      last_err_d   = last_err_q;
      case (state_q)
         IDLE: begin
            if (iIN_VALID && iFHT_RDY) state_d = LOAD;
         end
         LOAD: begin
            if (in_hs) begin
               idx_d = idx_q + 1'b1;
               if (iIN_LAST != is_last_idx) last_err_d = 1'b1;
               if (is_last_idx) begin
                  idx_d   = '0;
                  state_d = START;
               end
            end
         end
         START: begin
            start_cnt_d = start_cnt_q + 1'b1;
            seen_low_d  = seen_low_q || !iFHT_RDY;
            if (start_cnt_q == 8'(START_LEN - 1)) state_d = WAIT;
         end
         WAIT: begin
            seen_low_d = seen_low_q || !iFHT_RDY;
            if (rdy_rise) begin
               rd_set_d = iFHT_SOURCE;
               state_d  = UNLOAD;
            end
         end
         UNLOAD: begin
            if (issue) begin
               k_d = k_q + 1'b1;
               if (k_q == LAST_IDX) issue_done_d = 1'b1;
            end
            if (out_hs) begin
               out_cnt_d = out_cnt_q + 1'b1;
               if (out_cnt_q == LAST_IDX) begin
                  state_d      = IDLE;
                  k_d          = '0;
                  out_cnt_d    = '0;
                  issue_done_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         k_q          <= '0;
         out_cnt_q    <= '0;
         issue_done_q <= 1'b0;
         start_cnt_q  <= '0;
         rdy_prev_q   <= 1'b0;
         seen_low_q   <= 1'b0;
         rd_set_q     <= 1'b0;
         last_err_q   <= 1'b0;
         pipe_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         k_q          <= k_d;
         out_cnt_q    <= out_cnt_d;
         issue_done_q <= issue_done_d;
         start_cnt_q  <= start_cnt_d;
         rdy_prev_q   <= iFHT_RDY;
         seen_low_q   <= seen_low_d;
         rd_set_q     <= rd_set_d;
         last_err_q   <= last_err_d;
         pipe_q       <= pipe_d;
      end
   end

   fht_io_skid #(
      .DW    (16),
      .DEPTH (DEPTH)
   ) u_skid (
      .iCLK        (iCLK),
      .iRESET      (iRESET),
      .push_i      (pipe_q[RD_LAT-1]),
      .push_data_i (iRD_DATA),
      .pop_i       (out_hs),
      .data_o      (skid_data),
      .valid_o     (skid_valid),
      .count_o     (skid_count)
   );

   assign oIN_READY    = (state_q == LOAD);
   assign oIN_LAST_ERR = last_err_q;
   assign oWR_ADDR     = r[LOGN-1:2];
   assign oWR_EN       = in_hs ? (4'b0001 << r[1:0]) : 4'b0000;
   assign oFHT_START   = (state_q == START);
   assign oRD_SET      = rd_set_q;
   assign oRD_ADDR     = k_q[LOGN-1:2];
   assign oRD_BANK     = k_q[1:0];
   assign oOUT_DATA    = skid_data;
   assign oOUT_VALID   = skid_valid;
   assign oOUT_LAST    = skid_valid && (out_cnt_q == LAST_IDX);
   assign oBUSY        = (state_q != IDLE);
   assign oDBG_STATE   = state_q;
endmodule
